// File: rtl/ring_sequence_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : ring_sequence_monitor_if
// Description : Bundle between a 4-bit one-hot ring counter output and its
//               downstream sequence monitor.
//               Count_in   - ring counter state seen by the monitor
//               Locked     - monitor is locked onto the rotation
//               Rev_strobe - one-cycle pulse per completed revolution
//               Rev_count  - completed revolutions since reset (wraps)
//               Fault      - sticky fault flag
//               Fault_code - 00 none, 01 NOT_ONEHOT, 10 BAD_STEP, 11 STALL
//               master : side that drives Count_in and observes status
//               slave  : the monitor itself
// Revision    : 1.0 - initial release
// ============================================================================
interface ring_sequence_monitor_if #(
    parameter int WIDTH = 4,
    parameter int REV_W = 8
);
    logic [WIDTH-1:0] Count_in;
    logic             Locked;
    logic             Rev_strobe;
    logic [REV_W-1:0] Rev_count;
    logic             Fault;
    logic [1:0]       Fault_code;

    modport master (
        output Count_in,
        input  Locked,
        input  Rev_strobe,
        input  Rev_count,
        input  Fault,
        input  Fault_code
    );

    modport slave (
        input  Count_in,
        output Locked,
        output Rev_strobe,
        output Rev_count,
        output Fault,
        output Fault_code
    );
endinterface
`default_nettype wire

// File: rtl/ring_sequence_monitor.sv
`default_nettype none
// ============================================================================
// Module      : ring_sequence_monitor
// Description : Self-check for a one-hot ring counter. Tracks the rotation
//               0001->0010->0100->1000->0001, locks after LOCK_CYCLES good
//               steps, counts revolutions with a strobe per wrap, and raises
//               a sticky coded fault on an illegal value, illegal step or
//               stall longer than STALL_MAX cycles.
// Ports       : Clock - rising-edge clock shared with the ring counter
//               Reset - synchronous, active-high reset
//               mon   - slave side of ring_sequence_monitor_if
//                       (Count_in in; Locked, Rev_strobe, Rev_count, Fault,
//                        Fault_code out, all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module ring_sequence_monitor #(
    parameter int WIDTH       = 4,
    parameter int REV_W       = 8,
    parameter int LOCK_CYCLES = 2,
    parameter int STALL_MAX   = 3
) (
    input  wire logic               Clock,
    input  wire logic               Reset,
    ring_sequence_monitor_if.slave  mon
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] c_WRAP       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [3:0]       c_LOCK_LAST  = 4'(LOCK_CYCLES - 1);
    localparam logic [3:0]       c_STALL_LAST = 4'(STALL_MAX - 1);
    localparam logic [3:0]       c_STALL_MAX  = 4'(STALL_MAX);

    localparam logic [1:0] c_CODE_ONEHOT = 2'b01;
    localparam logic [1:0] c_CODE_STEP   = 2'b10;
    localparam logic [1:0] c_CODE_STALL  = 2'b11;

    state_t           state_q;
    logic [WIDTH-1:0] prev_q;
    logic [3:0]       good_cnt_q;
    logic [3:0]       stall_cnt_q;
    logic             locked_q;
    logic             strobe_q;
    logic [REV_W-1:0] rev_count_q;
    logic             fault_q;
    logic [1:0]       code_q;

    logic [WIDTH-1:0] w_cnt;
    logic [WIDTH-1:0] w_rot;
    logic             w_onehot;
    logic             w_good;
    logic             w_hold;

    assign w_cnt    = mon.Count_in;
    // Expected next value: previous sample rotated left, MSB wrapping to bit 0.
    assign w_rot    = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
    // Clearing the lowest set bit leaves zero only for a single set bit.
    assign w_onehot = (w_cnt != '0) && ((w_cnt & (w_cnt - c_WRAP)) == '0);
    assign w_good   = (w_cnt == w_rot);
    assign w_hold   = (w_cnt == prev_q);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            prev_q      <= '0;
            good_cnt_q  <= '0;
            stall_cnt_q <= '0;
            locked_q    <= 1'b0;
            strobe_q    <= 1'b0;
            rev_count_q <= '0;
            fault_q     <= 1'b0;
            code_q      <= 2'b00;
        end else begin
            strobe_q <= 1'b0;
            // prev freezes in FAULT so the offending context is preserved.
            if (state_q != ST_FAULT) begin
                prev_q <= w_cnt;
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_onehot) begin
                        state_q     <= ST_SYNC;
                        good_cnt_q  <= '0;
                        stall_cnt_q <= '0;
                    end
                end

                ST_SYNC: begin
                    // Before lock, any irregularity just drops back to IDLE.
                    if (!w_onehot || !(w_good || w_hold)) begin
                        state_q <= ST_IDLE;
                    end else if (w_good) begin
                        stall_cnt_q <= '0;
                        if (good_cnt_q == c_LOCK_LAST) begin
                            state_q  <= ST_LOCKED;
                            locked_q <= 1'b1;
                        end else begin
                            good_cnt_q <= good_cnt_q + 4'd1;
                        end
                    end else begin
                        if (stall_cnt_q == c_STALL_LAST) begin
                            state_q <= ST_IDLE;
                        end else begin
                            stall_cnt_q <= stall_cnt_q + 4'd1;
                        end
                    end
                end

                ST_LOCKED: begin
                    if (!w_onehot) begin
                        state_q  <= ST_FAULT;
                        locked_q <= 1'b0;
                        fault_q  <= 1'b1;
                        code_q   <= c_CODE_ONEHOT;
                    end else if (w_good) begin
                        stall_cnt_q <= '0;
                        if (w_cnt == c_WRAP) begin
                            strobe_q    <= 1'b1;
                            rev_count_q <= rev_count_q + 1'b1;
                        end
                    end else if (w_hold) begin
                        // Fault only when the hold count would pass STALL_MAX.
                        if (stall_cnt_q == c_STALL_MAX) begin
                            state_q  <= ST_FAULT;
                            locked_q <= 1'b0;
                            fault_q  <= 1'b1;
                            code_q   <= c_CODE_STALL;
                        end else begin
                            stall_cnt_q <= stall_cnt_q + 4'd1;
                        end
                    end else begin
                        state_q  <= ST_FAULT;
                        locked_q <= 1'b0;
                        fault_q  <= 1'b1;
                        code_q   <= c_CODE_STEP;
                    end
                end

                ST_FAULT: begin
                    // Sticky until Reset.
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mon.Locked     = locked_q;
    assign mon.Rev_strobe = strobe_q;
    assign mon.Rev_count  = rev_count_q;
    assign mon.Fault      = fault_q;
    assign mon.Fault_code = code_q;

endmodule
`default_nettype wire

// File: tb/tb_ring_sequence_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_ring_sequence_monitor
// Description : Directed self-checking bench for ring_sequence_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_sequence_monitor;

    logic Clock;
    logic Reset;
    int   n_checks;
    int   n_pass;
    int   strobes;

    ring_sequence_monitor_if #(.WIDTH(4), .REV_W(8)) mon_if ();

    ring_sequence_monitor #(
        .WIDTH       (4),
        .REV_W       (8),
        .LOCK_CYCLES (2),
        .STALL_MAX   (3)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .mon   (mon_if.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one value, let one edge sample it, observe just after the edge.
    task automatic step(input logic [3:0] v);
        @(negedge Clock);
        mon_if.Count_in = v;
        @(posedge Clock);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_locked"}, 32'(mon_if.Locked), 32'd0);
        check({tag, "_strobe"}, 32'(mon_if.Rev_strobe), 32'd0);
        check({tag, "_revcnt"}, 32'(mon_if.Rev_count), 32'd0);
        check({tag, "_fault"},  32'(mon_if.Fault), 32'd0);
        check({tag, "_code"},   32'(mon_if.Fault_code), 32'd0);
    endtask

    task automatic do_reset(input int n);
        @(negedge Clock);
        Reset = 1'b1;
        mon_if.Count_in = 4'b0001;
        repeat (n) @(posedge Clock);
        #1;
        check_reset_state("rst");
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    // Reset then 0001,0010,0100: locked after the edge sampling 0100.
    task automatic reset_and_lock();
        do_reset(1);
        step(4'b0001);
        step(4'b0010);
        step(4'b0100);
        check("lock", 32'(mon_if.Locked), 32'd1);
    endtask

    initial begin
        logic [3:0] v;
        n_checks = 0;
        n_pass   = 0;
        Reset    = 1'b1;
        mon_if.Count_in = 4'b0001;

        // ---- Lock and count ----
        do_reset(5);
        step(4'b0001); check("t1_lk0", 32'(mon_if.Locked), 32'd0);
        step(4'b0010); check("t1_lk1", 32'(mon_if.Locked), 32'd0);
        step(4'b0100); check("t1_lk2", 32'(mon_if.Locked), 32'd1);
        step(4'b1000); check("t1_st0", 32'(mon_if.Rev_strobe), 32'd0);
        step(4'b0001);
        check("t1_st1",  32'(mon_if.Rev_strobe), 32'd1);
        check("t1_rev",  32'(mon_if.Rev_count), 32'd1);
        check("t1_flt",  32'(mon_if.Fault), 32'd0);
        step(4'b0010);
        check("t1_st2",  32'(mon_if.Rev_strobe), 32'd0);

        // ---- Long run: 1024 revolutions wraps an 8-bit counter to 0 ----
        reset_and_lock();
        strobes = 0;
        for (int r = 0; r < 1024; r++) begin
            for (int k = 0; k < 4; k++) begin
                case (k)
                    0:       v = 4'b1000;
                    1:       v = 4'b0001;
                    2:       v = 4'b0010;
                    default: v = 4'b0100;
                endcase
                step(v);
                check("t2_strobe", 32'(mon_if.Rev_strobe), (v == 4'b0001) ? 32'd1 : 32'd0);
                if (mon_if.Rev_strobe) strobes++;
            end
            check("t2_rev", 32'(mon_if.Rev_count), 32'((r + 1) % 256));
        end
        check("t2_nstrobe", 32'(strobes), 32'd1024);
        check("t2_revend",  32'(mon_if.Rev_count), 32'd0);
        check("t2_fault",   32'(mon_if.Fault), 32'd0);

        // ---- Stall tolerance: 3 extra holds is fine ----
        reset_and_lock();
        repeat (3) begin
            step(4'b0100);
            check("t3_ok_flt", 32'(mon_if.Fault), 32'd0);
            check("t3_ok_lk",  32'(mon_if.Locked), 32'd1);
        end
        step(4'b1000);
        step(4'b0001);
        check("t3_strobe", 32'(mon_if.Rev_strobe), 32'd1);
        check("t3_rev",    32'(mon_if.Rev_count), 32'd1);
        // ---- Stall fault: 4 extra holds ----
        step(4'b0010);
        step(4'b0100);
        repeat (3) step(4'b0100);
        check("t3_pre_flt", 32'(mon_if.Fault), 32'd0);
        step(4'b0100);
        check("t3_flt",  32'(mon_if.Fault), 32'd1);
        check("t3_code", 32'(mon_if.Fault_code), 32'd3);
        check("t3_lk",   32'(mon_if.Locked), 32'd0);

        // ---- Illegal value, then fault is sticky ----
        reset_and_lock();
        step(4'b1000);
        step(4'b0001);
        check("t4_rev1", 32'(mon_if.Rev_count), 32'd1);
        step(4'b0010);
        step(4'b0110);
        check("t4_flt",  32'(mon_if.Fault), 32'd1);
        check("t4_code", 32'(mon_if.Fault_code), 32'd1);
        check("t4_lk",   32'(mon_if.Locked), 32'd0);
        for (int i = 0; i < 10; i++) begin
            case (i % 4)
                0:       v = 4'b0100;
                1:       v = 4'b1000;
                2:       v = 4'b0001;
                default: v = 4'b0010;
            endcase
            step(v);
            check("t4_sflt",  32'(mon_if.Fault), 32'd1);
            check("t4_scode", 32'(mon_if.Fault_code), 32'd1);
            check("t4_srev",  32'(mon_if.Rev_count), 32'd1);
            check("t4_sstb",  32'(mon_if.Rev_strobe), 32'd0);
        end

        // ---- Bad step, reset out of FAULT, relock ----
        reset_and_lock();
        step(4'b1000);
        step(4'b0001);
        step(4'b0010);
        step(4'b1000);
        check("t5_flt",  32'(mon_if.Fault), 32'd1);
        check("t5_code", 32'(mon_if.Fault_code), 32'd2);
        check("t5_rev",  32'(mon_if.Rev_count), 32'd1);
        do_reset(1);
        step(4'b0001);
        step(4'b0010);
        step(4'b0100);
        check("t5_relock", 32'(mon_if.Locked), 32'd1);
        check("t5_reflt",  32'(mon_if.Fault), 32'd0);

        // ---- Pre-lock tolerance ----
        do_reset(1);
        step(4'b0001);
        step(4'b0010);
        step(4'b0000);
        check("t6_lk",   32'(mon_if.Locked), 32'd0);
        check("t6_flt",  32'(mon_if.Fault), 32'd0);
        step(4'b0001);
        step(4'b0010);
        check("t6_lk1",  32'(mon_if.Locked), 32'd0);
        step(4'b0100);
        check("t6_lk2",  32'(mon_if.Locked), 32'd1);
        check("t6_flt2", 32'(mon_if.Fault), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ring_sequence_monitor.md
Name: ring_sequence_monitor

Overview:
Downstream checker for the 4-bit one-hot ring counter output (Count_out). It tracks the rotation 0001->0010->0100->1000->0001 and locks once the sequence is stable. It counts completed revolutions and emits a one-cycle strobe per revolution. It raises a sticky coded fault on an illegal value, an illegal step or an excessive stall, giving the design a self-check on the ring counter.

Parameters:
WIDTH, 4, ring width; Count_in is one-hot in legal operation.
REV_W, 8, width of the revolution counter.
LOCK_CYCLES, 2, consecutive good steps required to go from SYNC to LOCKED (range 1..15).
STALL_MAX, 3, consecutive cycles Count_in may hold its value without fault (range 1..15).

Ports:
Clock  input  1  rising-edge clock, shared with ring_counter.
Reset  input  1  synchronous, active-high reset.
Count_in  input  WIDTH  ring counter state (connect to Count_out).
Locked  output  1  high while the FSM is in LOCKED.
Rev_strobe  output  1  one-cycle pulse per completed revolution.
Rev_count  output  REV_W  completed revolutions since reset; wraps.
Fault  output  1  sticky fault flag.
Fault_code  output  2  00 none, 01 NOT_ONEHOT, 10 BAD_STEP, 11 STALL.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values: Locked=0, Rev_strobe=0, Rev_count=0, Fault=0, Fault_code=00. Internal: state=IDLE, prev=0, good_cnt=0, stall_cnt=0.
- Reset mid-operation: the same clear takes effect on the next edge, from any state, including FAULT.
- Definitions, all evaluated at each rising edge using Count_in and prev (Count_in registered on the previous edge):
  - onehot: exactly one bit of Count_in is set.
  - good step: Count_in equals prev rotated left by one; bit WIDTH-1 wraps to bit 0.
  - hold: Count_in equals prev.
- prev: loads Count_in every cycle, except in FAULT, where it freezes.
- IDLE: non-one-hot values (for example 0000 while the ring is in reset) are ignored. A one-hot value moves to SYNC with good_cnt=0.
- SYNC:
  - good step: good_cnt increments; on reaching LOCKED_CYCLES move to LOCKED.
  - hold: good_cnt is unchanged; stall_cnt increments.
  - not-one-hot or bad step: return to IDLE with no fault.
  - stall_cnt reaching STALL_MAX: return to IDLE.
- LOCKED, Locked=1:
  - good step: stall_cnt clears. If Count_in==0001 (a wrap), Rev_strobe=1 for one cycle and Rev_count increments. Rev_count wraps from 2^REV_W-1 to 0.
  - hold: stall_cnt increments. When stall_cnt would exceed STALL_MAX, enter FAULT with code 11.
  - not-one-hot: enter FAULT with code 01.
  - one-hot but not a good step or hold: enter FAULT with code 10.
- FAULT: Fault=1, Locked=0, Rev_strobe=0. Fault_code and Rev_count hold. Exit only via Reset.
- Priority when conditions coincide: NOT_ONEHOT > BAD_STEP > STALL.
- Latency: each response is visible in the cycle after the edge that samples the causing Count_in value.
- Any hold resets nothing in SYNC except through stall_cnt. stall_cnt clears on every good step.

Test Plan:
- Lock and count: Reset for 5 cycles with Count_in=0001, release, then drive 0001,0010,0100,1000,0001 (one per cycle). Locked=1 after the edge sampling 0100. One Rev_strobe pulse after the final 0001. Rev_count=1. Fault=0.
- Long run and wrap: with REV_W=8, drive 1024 revolutions. Rev_count=0 at the end. Exactly 1024 strobes, each 1 cycle wide, spaced 4 cycles apart.
- Stall: once locked, hold 0100 for 3 extra cycles then resume; no fault. Separately, hold 0100 for 4 extra cycles; Fault=1, Fault_code=11, Locked=0.
- Illegal value: once locked, drive 0110; Fault=1, Fault_code=01. Then drive a legal sequence for 10 cycles; Fault and Fault_code remain and Rev_count is frozen.
- Bad step: once locked, drive 0010 -> 1000; Fault_code=10. Then assert Reset for 1 cycle; all outputs return to reset values and the monitor relocks on the next legal sequence.
- Pre-lock tolerance: in SYNC after 0001,0010, drive 0000; the FSM returns to IDLE with Fault=0. A following legal sequence locks normally.
